hill_cipher_crypto: RTL and testbench

HILL_CIPHER_CRYPTO -- requirements
Module: hill_cipher_crypto

---
 rtl/hill_cipher_pkg.sv | 46 ++++
 rtl/hill_key_inv3.sv | 42 ++++
 rtl/hill_cipher_crypto.sv | 157 +++++++++++++++
 tb/tb_hill_cipher_crypto.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hill_cipher_pkg.sv
// Shared constants, types and mod-26 helpers for the Hill cipher block.
package hill_cipher_pkg;

  localparam int unsigned MOD     = 26;
  localparam logic [7:0]  ASCII_A = 8'h41;

  typedef logic [4:0] res_t;

  typedef enum logic [1:0] {
    IDLE,
    INV,
    CALC,
    DONE
  } state_t;

  // Letters of either case map to their alphabet position; anything else folds mod 26.
  function automatic res_t char_to_idx(input logic [31:0] ch);
    if (ch >= 32'd65 && ch <= 32'd90) begin
      return res_t'(ch - 32'd65);
    end else if (ch >= 32'd97 && ch <= 32'd122) begin
      return res_t'(ch - 32'd97);
    end else begin
      return res_t'(ch % 32'd26);
    end
  endfunction

  // Multiplicative inverse mod 26; non-invertible residues return 0.
  function automatic res_t inv_mod26(input res_t r);
    case (r)
      5'd1:    return 5'd1;
      5'd3:    return 5'd9;
      5'd5:    return 5'd21;
      5'd7:    return 5'd15;
      5'd9:    return 5'd3;
      5'd11:   return 5'd19;
      5'd15:   return 5'd7;
      5'd17:   return 5'd23;
      5'd19:   return 5'd11;
      5'd21:   return 5'd5;
      5'd23:   return 5'd17;
      5'd25:   return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/hill_key_inv3.sv
// Combinational 3x3 adjugate and determinant of the key matrix, reduced mod 26.
module hill_key_inv3
  import hill_cipher_pkg::*;
(
  input  res_t key [9],
  output res_t adj [9],
  output res_t det
);

  function automatic res_t mod26s(input int x);
    int r;
    r = x % 26;
    if (r < 0) r = r + 26;
    return res_t'(r);
  endfunction

  int cof [9];
  int det_acc;

  // Cyclic index form yields signed cofactors directly for a 3x3 matrix.
  always_comb begin
    cof     = '{default: 0};
    adj     = '{default: '0};
    det_acc = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        cof[i*3+j] = int'(key[((i+1)%3)*3 + (j+1)%3]) * int'(key[((i+2)%3)*3 + (j+2)%3])
                   - int'(key[((i+1)%3)*3 + (j+2)%3]) * int'(key[((i+2)%3)*3 + (j+1)%3]);
      end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        adj[j*3+i] = mod26s(cof[i*3+j]);
      end
    end
    for (int unsigned j = 0; j < 3; j++) begin
      det_acc = det_acc + int'(key[j]) * cof[j];
    end
    det = mod26s(det_acc);
  end

endmodule

// File: rtl/hill_cipher_crypto.sv
// Hill cipher block engine: key/text memories, optional 3x3 key inversion, one output row per cycle.
module hill_cipher_crypto
  import hill_cipher_pkg::*;
#(
  parameter int BLOCK_SIZE = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    mode,
  input  logic [DATA_WIDTH-1:0]                   key_data,
  input  logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0] key_addr,
  input  logic                                    key_wen,
  input  logic [DATA_WIDTH-1:0]                   text_in,
  input  logic [$clog2(BLOCK_SIZE)-1:0]           text_in_addr,
  input  logic                                    text_in_wen,
  output logic [DATA_WIDTH-1:0]                   text_out,
  output logic                                    text_out_valid,
  output logic                                    done
);

  localparam int NN     = BLOCK_SIZE * BLOCK_SIZE;
  localparam int RW     = $clog2(BLOCK_SIZE);
  localparam int SUM_W  = (BLOCK_SIZE * 625 >= 2048) ? $clog2(BLOCK_SIZE * 625 + 1) : 11;
  localparam bit DEC_OK = (BLOCK_SIZE == 3);

  state_t                state, state_d;
  res_t                  key_mem  [NN];
  logic [DATA_WIDTH-1:0] text_mem [BLOCK_SIZE];
  res_t                  adj      [NN];
  res_t                  det;
  res_t                  adj_q    [NN];
  res_t                  det_inv_q;
  res_t                  inv_q    [NN];
  logic                  mode_q;
  logic                  inv_step;
  logic [RW-1:0]         row;

  logic                  capture, ld_adj, ld_inv, emit, fin;
  logic [SUM_W-1:0]      acc;
  res_t                  m, p, row_res;

  if (BLOCK_SIZE == 3) begin : g_inv
    hill_key_inv3 u_key_inv (
      .key (key_mem),
      .adj (adj),
      .det (det)
    );
  end else begin : g_noinv
    always_comb begin
      adj = '{default: '0};
      det = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    capture = 1'b0;
    ld_adj  = 1'b0;
    ld_inv  = 1'b0;
    emit    = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = (mode && DEC_OK) ? INV : CALC;
        end
      end
      INV: begin
        if (!inv_step) begin
          ld_adj = 1'b1;
        end else begin
          ld_inv  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        emit = 1'b1;
        if (int'(row) == BLOCK_SIZE - 1) state_d = DONE;
      end
      DONE: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Dot product of the selected matrix row with the mapped text vector.
  always_comb begin
    acc = '0;
    m   = '0;
    p   = '0;
    for (int unsigned c = 0; c < BLOCK_SIZE; c++) begin
      m   = mode_q ? inv_q[int'(row) * BLOCK_SIZE + c] : key_mem[int'(row) * BLOCK_SIZE + c];
      p   = char_to_idx(32'(text_mem[c]));
      acc = acc + SUM_W'(m) * SUM_W'(p);
    end
    row_res = res_t'(acc % SUM_W'(MOD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NN; i++) begin
        key_mem[i] <= '0;
        adj_q[i]   <= '0;
        inv_q[i]   <= '0;
      end
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
        text_mem[i] <= '0;
      end
      det_inv_q      <= '0;
      mode_q         <= 1'b0;
      inv_step       <= 1'b0;
      row            <= '0;
      text_out       <= '0;
      text_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      text_out_valid <= emit;
      done           <= fin;
      if (state == IDLE && key_wen && int'(key_addr) < NN) begin
        key_mem[key_addr] <= res_t'(key_data % DATA_WIDTH'(MOD));
      end
      if (state == IDLE && text_in_wen && int'(text_in_addr) < BLOCK_SIZE) begin
        text_mem[text_in_addr] <= text_in;
      end
      if (capture) begin
        mode_q   <= mode & DEC_OK;
        inv_step <= 1'b0;
        row      <= '0;
      end
      if (ld_adj) begin
        adj_q     <= adj;
        det_inv_q <= inv_mod26(det);
        inv_step  <= 1'b1;
      end
      if (ld_inv) begin
        for (int unsigned i = 0; i < NN; i++) begin
          inv_q[i] <= res_t'((10'(adj_q[i]) * 10'(det_inv_q)) % 10'(MOD));
        end
      end
      if (emit) begin
        text_out <= DATA_WIDTH'(ASCII_A) + DATA_WIDTH'(row_res);
        row      <= row + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hill_cipher_crypto.sv
// Scoreboard bench for hill_cipher_crypto: directed blocks, queue of expected outputs, negedge monitor.
module tb_hill_cipher_crypto;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] key_data;
  logic [3:0] key_addr;
  logic       key_wen;
  logic [7:0] text_in;
  logic [1:0] text_in_addr;
  logic       text_in_wen;
  logic [7:0] text_out;
  logic       text_out_valid;
  logic       done;

  localparam int DONE_TOK = 256;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q [$];
  int nvalid;
  int first_cyc;
  int done_cyc;
  bit done_seen;
  int key_vec [9];

  hill_cipher_crypto #(.BLOCK_SIZE(3), .DATA_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .key_data       (key_data),
    .key_addr       (key_addr),
    .key_wen        (key_wen),
    .text_in        (text_in),
    .text_in_addr   (text_in_addr),
    .text_in_wen    (text_in_wen),
    .text_out       (text_out),
    .text_out_valid (text_out_valid),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (text_out_valid === 1'b1) begin
      if (nvalid == 0) first_cyc = cyc;
      nvalid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0d required=none", text_out);
      end else begin
        e = exp_q.pop_front();
        check("text_out", 32'(text_out), 32'(e));
      end
    end
    if (done === 1'b1) begin
      done_cyc  = cyc;
      done_seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("done_order", 32'(e), 32'(DONE_TOK));
      end
    end
  end

  task automatic load_key();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      key_wen  = 1'b1;
      key_addr = 4'(i);
      key_data = 8'(key_vec[i]);
    end
    @(negedge clk);
    key_wen = 1'b0;
  endtask

  task automatic load_text(input logic [23:0] t);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      text_in_wen  = 1'b1;
      text_in_addr = 2'(i);
      text_in      = t[23-8*i -: 8];
    end
    @(negedge clk);
    text_in_wen = 1'b0;
  endtask

  task automatic run_block(input string name, input bit md, input logic [23:0] exp,
                           input int lat, input bit poke);
    int s;
    int waited;
    logic [7:0] ch;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ch = exp[23-8*i -: 8];
      exp_q.push_back(int'(ch));
    end
    exp_q.push_back(DONE_TOK);
    nvalid    = 0;
    done_seen = 1'b0;
    first_cyc = -1;
    done_cyc  = -1;
    start     = 1'b1;
    mode      = md;
    s         = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    if (poke) begin
      @(negedge clk);
      start    = 1'b1;
      mode     = ~md;
      key_wen  = 1'b1;
      key_addr = 4'd4;
      key_data = 8'd5;
      @(posedge clk);
      #1;
      start   = 1'b0;
      key_wen = 1'b0;
    end
    waited = 0;
    while (!done_seen && waited < 30) begin
      @(posedge clk);
      waited++;
    end
    if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
      exp_q.delete();
    end else begin
      check({name, "_first_latency"}, 32'(first_cyc - s), 32'(2 + lat));
      check({name, "_done_latency"},  32'(done_cyc - s),  32'(5 + lat));
      check({name, "_valid_count"},   32'(nvalid), 32'd3);
      check({name, "_pending"},       32'(exp_q.size()), 32'd0);
    end
    @(negedge clk);
    check({name, "_valid_low"}, 32'(text_out_valid), 32'd0);
    check({name, "_hold"},      32'(text_out), 32'(exp[7:0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    key_data = '0; key_addr = '0; key_wen = 1'b0;
    text_in = '0; text_in_addr = '0; text_in_wen = 1'b0;
    #2;
    check("reset_text_out", 32'(text_out), 32'd0);
    check("reset_valid",    32'(text_out_valid), 32'd0);
    check("reset_done",     32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    key_vec = '{6, 24, 1, 13, 16, 10, 20, 17, 15};
    load_key();
    load_text("ACT");
    run_block("enc_act", 1'b0, "POH", 0, 1'b0);
    load_text("POH");
    run_block("dec_poh", 1'b1, "ACT", 2, 1'b0);
    load_text("act");
    run_block("enc_lower", 1'b0, "POH", 0, 1'b0);

    key_vec = '{27, 0, 0, 0, 27, 0, 0, 0, 27};
    load_key();
    load_text("XYZ");
    run_block("enc_ident", 1'b0, "XYZ", 0, 1'b0);

    key_vec = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_key();
    load_text("HEY");
    run_block("dec_singular", 1'b1, "AAA", 2, 1'b0);

    key_vec = '{6, 24, 1, 13, 16, 10, 20, 17, 15};
    load_key();
    load_text("ACT");
    run_block("enc_poke", 1'b0, "POH", 0, 1'b1);
    run_block("enc_repeat", 1'b0, "POH", 0, 1'b0);

    // Abort mid-block: only the first character may appear.
    @(negedge clk);
    exp_q.push_back(32'h50);
    nvalid    = 0;
    done_seen = 1'b0;
    start     = 1'b1;
    mode      = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_text_out", 32'(text_out), 32'd0);
    check("abort_valid",    32'(text_out_valid), 32'd0);
    check("abort_done",     32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    check("abort_nvalid",    32'(nvalid), 32'd1);
    check("abort_done_seen", 32'(done_seen), 32'd0);
    check("abort_pending",   32'(exp_q.size()), 32'd0);

    run_block("enc_cleared", 1'b0, "AAA", 0, 1'b0);
    load_key();
    load_text("ACT");
    run_block("enc_after_rst", 1'b0, "POH", 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
